// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage, runs loads/stores on a req/ack data bus, resolves branches.
module mem_access_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pcWithImm_i,
    input  logic            zero_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic            branch_i,
    input  logic            mem_rena_i,
    input  logic            mem_wena_i,
    input  logic            mem2reg_i,
    input  logic [XLEN-1:0] reg2_data_i,
    input  logic [2:0]      funct3_i,
    input  logic [4:0]      reg_waddr_i,
    input  logic            reg_wena_i,
    output logic            pc_src_o,
    output logic [XLEN-1:0] branch_target_o,
    output logic            stall_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    output logic [3:0]      dmem_be_o,
    input  logic [XLEN-1:0] dmem_rdata_i,
    input  logic            dmem_ack_i,
    output logic            wb_valid_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic [4:0]      wb_waddr_o,
    output logic            wb_wena_o,
    output logic            misalign_o
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUS  = 1'b1;

    logic [0:0]      state;
    logic [2:0]      q_f3;
    logic [1:0]      q_off;
    logic            q_load;
    logic            q_wena;
    logic [1:0]      off;
    logic            mem_op;
    logic            mis_op;
    logic            start;
    logic [3:0]      be_n;
    logic [XLEN-1:0] wdata_n;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] load_val;
    logic            unused;

    assign unused = mem2reg_i;
    assign off    = alu_result_i[1:0];
    assign mem_op = mem_rena_i | mem_wena_i;
    // funct3[1] set means word-sized, which also covers the reserved encodings
    assign mis_op = mem_op & ((funct3_i[1] & (off != 2'b00)) | (~funct3_i[1] & funct3_i[0] & off[0]));
    assign start  = (state == IDLE) & mem_op & ~mis_op;

    assign stall_o         = start | ((state == BUS) & ~dmem_ack_i);
    assign pc_src_o        = branch_i & zero_i & ~stall_o;
    assign branch_target_o = pcWithImm_i;

    assign be_n    = funct3_i[1] ? 4'b1111 : funct3_i[0] ? (4'b0011 << off) : (4'b0001 << off);
    assign wdata_n = funct3_i[1] ? reg2_data_i : funct3_i[0] ? {(XLEN/16){reg2_data_i[15:0]}} : {(XLEN/8){reg2_data_i[7:0]}};

    assign ld_byte  = dmem_rdata_i[{q_off, 3'b000} +: 8];
    assign ld_half  = dmem_rdata_i[{q_off[1], 4'b0000} +: 16];
    assign load_val = q_f3[1] ? dmem_rdata_i
                    : q_f3[0] ? {{(XLEN-16){~q_f3[2] & ld_half[15]}}, ld_half}
                    : {{(XLEN-8){~q_f3[2] & ld_byte[7]}}, ld_byte};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            dmem_be_o    <= 4'b0000;
            wb_valid_o   <= 1'b0;
            wb_data_o    <= '0;
            wb_waddr_o   <= 5'd0;
            wb_wena_o    <= 1'b0;
            misalign_o   <= 1'b0;
            q_f3         <= 3'd0;
            q_off        <= 2'd0;
            q_load       <= 1'b0;
            q_wena       <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                state        <= BUS;
                dmem_req_o   <= 1'b1;
                dmem_we_o    <= ~mem_rena_i;
                dmem_addr_o  <= {alu_result_i[XLEN-1:2], 2'b00};
                dmem_be_o    <= be_n;
                dmem_wdata_o <= wdata_n;
                q_f3         <= funct3_i;
                q_off        <= off;
                q_load       <= mem_rena_i;
                q_wena       <= reg_wena_i;
                wb_valid_o   <= 1'b0;
                wb_wena_o    <= 1'b0;
                wb_waddr_o   <= reg_waddr_i;
                misalign_o   <= 1'b0;
            end else begin
                wb_valid_o   <= 1'b1;
                wb_data_o    <= alu_result_i;
                wb_waddr_o   <= reg_waddr_i;
                wb_wena_o    <= reg_wena_i & ~mis_op;
                misalign_o   <= mis_op;
            end
        end else if (dmem_ack_i) begin
            state      <= IDLE;
            dmem_req_o <= 1'b0;
            wb_valid_o <= 1'b1;
            wb_wena_o  <= q_load & q_wena;
            wb_data_o  <= q_load ? load_val : wb_data_o;
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed checks of the MEM stage with hand-computed expectations.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcWithImm_i, alu_result_i, reg2_data_i, dmem_rdata_i;
    logic        zero_i, branch_i, mem_rena_i, mem_wena_i, mem2reg_i, reg_wena_i, dmem_ack_i;
    logic [2:0]  funct3_i;
    logic [4:0]  reg_waddr_i;
    logic        pc_src_o, stall_o, dmem_req_o, dmem_we_o, wb_valid_o, wb_wena_o, misalign_o;
    logic [31:0] branch_target_o, dmem_addr_o, dmem_wdata_o, wb_data_o;
    logic [3:0]  dmem_be_o;
    logic [4:0]  wb_waddr_o;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .pcWithImm_i(pcWithImm_i), .zero_i(zero_i),
        .alu_result_i(alu_result_i), .branch_i(branch_i), .mem_rena_i(mem_rena_i),
        .mem_wena_i(mem_wena_i), .mem2reg_i(mem2reg_i), .reg2_data_i(reg2_data_i),
        .funct3_i(funct3_i), .reg_waddr_i(reg_waddr_i), .reg_wena_i(reg_wena_i),
        .pc_src_o(pc_src_o), .branch_target_o(branch_target_o), .stall_o(stall_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_rdata_i(dmem_rdata_i),
        .dmem_ack_i(dmem_ack_i), .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o),
        .wb_waddr_o(wb_waddr_o), .wb_wena_o(wb_wena_o), .misalign_o(misalign_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in(input logic [31:0] alu, input logic [4:0] rd, input logic we);
        mem_rena_i = 0; mem_wena_i = 0; mem2reg_i = 0; branch_i = 0; zero_i = 0;
        alu_result_i = alu; reg_waddr_i = rd; reg_wena_i = we; funct3_i = 3'b010;
    endtask

    initial begin
        rst = 1; pcWithImm_i = 0; reg2_data_i = 0; dmem_rdata_i = 0; dmem_ack_i = 0;
        idle_in(32'h0, 5'd0, 1'b0);
        tick(); tick();
        chk("rst_valid", {31'b0, wb_valid_o}, 32'd0);
        chk("rst_req", {31'b0, dmem_req_o}, 32'd0);
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        chk("rst_wbdata", wb_data_o, 32'd0);
        chk("rst_be", {28'b0, dmem_be_o}, 32'd0);
        chk("rst_mis", {31'b0, misalign_o}, 32'd0);

        // ALU op and branch
        rst = 0;
        idle_in(32'h1234, 5'd5, 1'b1);
        #1 chk("alu_stall", {31'b0, stall_o}, 32'd0);
        tick();
        chk("alu_valid", {31'b0, wb_valid_o}, 32'd1);
        chk("alu_data", wb_data_o, 32'h1234);
        chk("alu_waddr", {27'b0, wb_waddr_o}, 32'd5);
        chk("alu_wena", {31'b0, wb_wena_o}, 32'd1);
        branch_i = 1; zero_i = 1; pcWithImm_i = 32'h200;
        #1 chk("br_src", {31'b0, pc_src_o}, 32'd1);
        chk("br_tgt", branch_target_o, 32'h200);
        zero_i = 0;
        #1 chk("br_nz", {31'b0, pc_src_o}, 32'd0);

        // LB at 0x103 with two wait cycles
        idle_in(32'h103, 5'd7, 1'b1);
        mem_rena_i = 1; mem2reg_i = 1; funct3_i = 3'b000;
        #1 chk("lb_stall0", {31'b0, stall_o}, 32'd1);
        tick();
        chk("lb_req", {31'b0, dmem_req_o}, 32'd1);
        chk("lb_addr", dmem_addr_o, 32'h100);
        chk("lb_we", {31'b0, dmem_we_o}, 32'd0);
        chk("lb_bubble", {31'b0, wb_valid_o}, 32'd0);
        chk("lb_stall1", {31'b0, stall_o}, 32'd1);
        branch_i = 1; zero_i = 1;
        #1 chk("br_stalled", {31'b0, pc_src_o}, 32'd0);
        tick();
        chk("lb_stall2", {31'b0, stall_o}, 32'd1);
        chk("lb_hold", {31'b0, dmem_req_o}, 32'd1);
        tick();
        dmem_ack_i = 1; dmem_rdata_i = 32'h80FF_0000;
        #1 chk("lb_ackstall", {31'b0, stall_o}, 32'd0);
        chk("lb_nores", {31'b0, wb_valid_o}, 32'd0);
        tick();
        dmem_ack_i = 0;
        idle_in(32'h55, 5'd0, 1'b0);
        chk("lb_valid", {31'b0, wb_valid_o}, 32'd1);
        chk("lb_data", wb_data_o, 32'hFFFF_FF80);
        chk("lb_waddr", {27'b0, wb_waddr_o}, 32'd7);
        chk("lb_wena", {31'b0, wb_wena_o}, 32'd1);
        chk("lb_reqdrop", {31'b0, dmem_req_o}, 32'd0);
        tick();
        chk("idle_data", wb_data_o, 32'h55);

        // SH at 0x22, ack in first BUS cycle
        idle_in(32'h22, 5'd0, 1'b0);
        mem_wena_i = 1; funct3_i = 3'b001; reg2_data_i = 32'hABCD_1234;
        #1 chk("sh_stall", {31'b0, stall_o}, 32'd1);
        tick();
        chk("sh_be", {28'b0, dmem_be_o}, 32'b1100);
        chk("sh_wdata", dmem_wdata_o, 32'h1234_1234);
        chk("sh_we", {31'b0, dmem_we_o}, 32'd1);
        chk("sh_addr", dmem_addr_o, 32'h20);
        dmem_ack_i = 1;
        #1 chk("sh_ackstall", {31'b0, stall_o}, 32'd0);
        tick();
        dmem_ack_i = 0;
        chk("sh_valid", {31'b0, wb_valid_o}, 32'd1);
        chk("sh_wena", {31'b0, wb_wena_o}, 32'd0);
        chk("sh_reqdrop", {31'b0, dmem_req_o}, 32'd0);

        // SB at 0x21
        idle_in(32'h21, 5'd0, 1'b0);
        mem_wena_i = 1; funct3_i = 3'b000; reg2_data_i = 32'h1111_117A;
        tick();
        chk("sb_be", {28'b0, dmem_be_o}, 32'b0010);
        chk("sb_wdata", dmem_wdata_o, 32'h7A7A_7A7A);
        dmem_ack_i = 1;
        tick();
        dmem_ack_i = 0;

        // LHU at 0x102, load+store both high behaves as load
        idle_in(32'h102, 5'd9, 1'b1);
        mem_rena_i = 1; mem_wena_i = 1; funct3_i = 3'b101;
        tick();
        chk("lhu_we", {31'b0, dmem_we_o}, 32'd0);
        dmem_ack_i = 1; dmem_rdata_i = 32'h8001_1234;
        tick();
        dmem_ack_i = 0;
        chk("lhu_data", wb_data_o, 32'h0000_8001);

        // LH at 0x102 sign-extends
        idle_in(32'h102, 5'd9, 1'b1);
        mem_rena_i = 1; funct3_i = 3'b001;
        tick();
        dmem_ack_i = 1;
        tick();
        dmem_ack_i = 0;
        chk("lh_data", wb_data_o, 32'hFFFF_8001);

        // misaligned LW at 0x41
        idle_in(32'h41, 5'd9, 1'b1);
        mem_rena_i = 1; funct3_i = 3'b010;
        #1 chk("mis_stall", {31'b0, stall_o}, 32'd0);
        tick();
        chk("mis_req", {31'b0, dmem_req_o}, 32'd0);
        chk("mis_flag", {31'b0, misalign_o}, 32'd1);
        chk("mis_wena", {31'b0, wb_wena_o}, 32'd0);
        chk("mis_valid", {31'b0, wb_valid_o}, 32'd1);
        idle_in(32'h0, 5'd0, 1'b0);
        tick();
        chk("mis_clear", {31'b0, misalign_o}, 32'd0);

        // reset during the second BUS cycle, then a late ack
        idle_in(32'h80, 5'd4, 1'b1);
        mem_rena_i = 1; funct3_i = 3'b010;
        tick();
        tick();
        chk("rb_req", {31'b0, dmem_req_o}, 32'd1);
        rst = 1;
        tick();
        rst = 0;
        idle_in(32'h99, 5'd3, 1'b1);
        chk("rb_reqdrop", {31'b0, dmem_req_o}, 32'd0);
        chk("rb_novalid", {31'b0, wb_valid_o}, 32'd0);
        dmem_ack_i = 1; dmem_rdata_i = 32'hDEAD_BEEF;
        #1 chk("rb_stall", {31'b0, stall_o}, 32'd0);
        tick();
        dmem_ack_i = 0;
        chk("rb_ignack", wb_data_o, 32'h99);
        chk("rb_req2", {31'b0, dmem_req_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
